tt_um_serial_adder: RTL and testbench
=====================================

TT_UM_SERIAL_ADDER -- requirements
Module: tt_um_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 clk  input  1  single clock; every register uses its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  power-good indication; always 1; functionally ignored.
REQ-005 ui_in  input  8  operand data bus, sampled by the load strobes.
REQ-006 uio_in  input  8  controls: [0] load_a, [1] load_b, [2] start; [7:3] unused.
REQ-007 uo_out  output  8  registered sum result.
REQ-008 uio_out  output  8  status: [3] carry_out, [4] busy, [5] done; all other bits 0.
REQ-009 uio_oe  output  8  SHALL be the constant 8'b0011_1000.

Function
REQ-010 The block SHALL add operand registers A and B bit-serially, LSB first, one bit per clock, through a full adder built from two half-adder cells plus an OR gate.
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, load_a high SHALL copy ui_in into A at that edge, and load_b high SHALL copy ui_in into B; both high SHALL load both.
REQ-013 start SHALL be rising-edge detected against a registered copy start_q; holding start high SHALL trigger exactly one operation.
REQ-014 A start edge seen in IDLE or DONE SHALL enter RUN on the same edge, clear carry and the bit counter, and clear done.
REQ-015 start SHALL take priority over load: loads presented in the same cycle as a start edge SHALL be ignored.
REQ-016 Each RUN cycle SHALL compute s = A[0]^B[0]^c, update c = majority(A[0],B[0],c), shift A and B right by 1, shift s into the MSB of the sum shift register, and increment the 3-bit counter.
REQ-017 At the RUN edge where the counter equals WIDTH-1, the FSM SHALL go to DONE, copy the sum shift register (including the final bit) into uo_out, and copy the final carry into carry_out.
REQ-018 busy SHALL be 1 exactly while the state is RUN, i.e. for WIDTH cycles after the start edge.
REQ-019 done SHALL be 1 while the state is DONE and SHALL hold until the next start edge.
REQ-020 Latency: result valid WIDTH clocks after the edge that detected start.
REQ-021 In RUN, load_a, load_b and start edges SHALL be ignored; A and B evolve only by shifting.
REQ-022 uo_out and carry_out SHALL hold the previous result throughout RUN and update only on entry to DONE.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, with the overflow bit presented on carry_out.

Reset
REQ-024 On rst_n low, all of the following SHALL clear to 0: A, B, sum shift register, carry, counter, start_q, uo_out, carry_out, busy and done; state SHALL go to IDLE.
REQ-025 Reset asserted mid-RUN SHALL abort the operation immediately; after release the block SHALL require a fresh start edge.
REQ-026 If start is already high when rst_n releases, it SHALL trigger an operation at the first clock edge (start_q resets to 0).

Structure
REQ-027 A shared package tt_serial_add_pkg SHALL hold WIDTH, the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the uio bit-index constants.
REQ-028 One sub-module, ha_cell (inputs a, b; outputs sum = a^b, carry = a&b), SHALL be instantiated twice to form the full adder.
REQ-029 Unused input bits (uio_in[7:3], ena) SHALL be collected into a single unused reduction wire.

Verification
REQ-030 Load A=0x3C, B=0x5A, pulse start -> busy for 8 cycles, then uo_out=0x96, carry_out=0, done=1.
REQ-031 A=0xFF, B=0x01 -> uo_out=0x00, carry_out=1; then A=0xFF, B=0xFF -> uo_out=0xFE, carry_out=1.
REQ-032 Hold start high for 30 cycles after A=0x01, B=0x02 -> exactly one busy window of 8 cycles; uo_out=0x03; done stays 1.
REQ-033 Assert load_a with ui_in=0xAA during RUN cycle 3 of 0x10+0x20 -> result 0x30; A holds 0x00 afterwards, not 0xAA.
REQ-034 Assert rst_n low during RUN cycle 4 -> all outputs 0 and state IDLE at once; a new start with A=0x07, B=0x09 gives 0x10.
REQ-035 Present load_a=1 (ui_in=0x55) in the same cycle as a start edge -> load ignored; result uses the old A.

Source files
------------

// File: rtl/tt_serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_serial_add_pkg
// Description : Shared width, state encoding and uio bit positions for the
//               bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_serial_add_pkg;

    // Operand / result width in bits
    localparam int WIDTH = 8;

    // Bit counter width (counts 0 .. WIDTH-1)
    localparam int CNT_W = 3;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // uio_in control bit positions
    localparam int UIO_LOAD_A = 0;
    localparam int UIO_LOAD_B = 1;
    localparam int UIO_START  = 2;

    // uio_out status bit positions
    localparam int UIO_CARRY  = 3;
    localparam int UIO_BUSY   = 4;
    localparam int UIO_DONE   = 5;

    // Only the status bits are driven outward
    localparam logic [7:0] UIO_OE_MASK = 8'b0011_1000;

endpackage : tt_serial_add_pkg
`default_nettype wire

// File: rtl/tt_um_serial_adder_ha_cell.sv
`default_nettype none
// ============================================================================
// Module      : ha_cell
// Description : Single-bit half adder; two of these plus an OR gate form the
//               full adder of the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module ha_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule : ha_cell
`default_nettype wire

// File: rtl/tt_um_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_serial_adder
// Description : Bit-serial adder. Operands A and B are loaded from ui_in,
//               a rising edge on start adds them LSB first at one bit per
//               clock, and the WIDTH-bit sum plus carry appear on the
//               outputs WIDTH clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_serial_adder #(
    parameter int WIDTH = tt_serial_add_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    import tt_serial_add_pkg::*;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic load_a;
    logic load_b;
    logic start;
    logic start_q;
    logic start_edge;

    assign load_a     = uio_in[UIO_LOAD_A];
    assign load_b     = uio_in[UIO_LOAD_B];
    assign start      = uio_in[UIO_START];
    assign start_edge = start & ~start_q;

    // Inputs that carry no function are folded together so they are
    // visibly consumed.
    logic unused;
    assign unused = &{1'b0, uio_in[7:3], ena};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_sr;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               carry_out;
    logic [CNT_W-1:0]   cnt;

    // FSM-issued datapath commands
    logic               do_start;
    logic               do_load;
    logic               do_shift;
    logic               do_finish;

    // ------------------------------------------------------------------
    // Full adder from two half adders and an OR gate
    // ------------------------------------------------------------------
    logic ha0_sum;
    logic ha0_carry;
    logic bit_sum;
    logic ha1_carry;
    logic bit_carry;

    ha_cell u_ha0 (
        .a     (a_reg[0]),
        .b     (b_reg[0]),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    ha_cell u_ha1 (
        .a     (ha0_sum),
        .b     (carry),
        .sum   (bit_sum),
        .carry (ha1_carry)
    );

    assign bit_carry = ha0_carry | ha1_carry;

    // Final bit of the operation is being processed this cycle
    logic last_bit;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Sum register contents including the bit produced this cycle
    logic [WIDTH-1:0] sum_next;
    assign sum_next = {bit_sum, sum_sr[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // Holds the controller state; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and datapath command decode; start beats load.
    always_comb begin
        next_state = state;
        do_start   = 1'b0;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    next_state = RUN;
                    do_start   = 1'b1;
                end else begin
                    do_load    = 1'b1;
                end
            end
            RUN: begin
                do_shift = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                    do_finish  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Start edge detector register, tracked in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // Operand load, serial shift/add and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            if (do_start) begin
                carry <= 1'b0;
                cnt   <= '0;
            end else if (do_load) begin
                if (load_a) begin
                    a_reg <= ui_in[WIDTH-1:0];
                end
                if (load_b) begin
                    b_reg <= ui_in[WIDTH-1:0];
                end
            end else if (do_shift) begin
                a_reg  <= a_reg >> 1;
                b_reg  <= b_reg >> 1;
                sum_sr <= sum_next;
                carry  <= bit_carry;
                cnt    <= cnt + 1'b1;
            end

            // Outputs change only on the edge that enters DONE
            if (do_finish) begin
                result    <= sum_next;
                carry_out <= bit_carry;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic busy;
    logic done;

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign uo_out = 8'(result);
    assign uio_oe = UIO_OE_MASK;

    // Status bus; undriven positions stay zero.
    always_comb begin
        uio_out            = 8'h00;
        uio_out[UIO_CARRY] = carry_out;
        uio_out[UIO_BUSY]  = busy;
        uio_out[UIO_DONE]  = done;
    end

endmodule : tt_um_serial_adder
`default_nettype wire

// File: tb/tb_tt_um_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_serial_adder
// Description : Self-checking bench for the bit-serial adder: directed
//               vector table, random operands against an arithmetic model,
//               and hand-written multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Result the DUT should be presenting from the previous operation
    logic [7:0] prev_sum   = 8'h00;
    logic       prev_carry = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    vec_t vecs[7];

    tt_um_serial_adder #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        ui_in  = a;
        uio_in = 8'h01;
        tick();
        ui_in  = b;
        uio_in = 8'h02;
        tick();
        uio_in = 8'h00;
    endtask

    // Apply the start cycle, run to completion and check the result.
    // inject > 0 drives load_a with 0xAA during that RUN cycle.
    task automatic run_op(input string tag, input logic [7:0] start_uio,
                          input logic [7:0] start_ui, input logic [7:0] exp_sum,
                          input logic exp_carry, input int inject);
        int n;
        bit held;
        ui_in  = start_ui;
        uio_in = start_uio;
        tick();
        uio_in = 8'h00;
        check({tag, ".busy_at_start"}, 32'(uio_out[4]), 32'd1);
        check({tag, ".done_cleared"}, 32'(uio_out[5]), 32'd0);
        n    = 0;
        held = 1'b1;
        while (uio_out[4] === 1'b1 && n < 20) begin
            if (inject > 0 && n == inject - 1) begin
                ui_in  = 8'hAA;
                uio_in = 8'h01;
            end else begin
                uio_in = 8'h00;
            end
            if (uo_out !== prev_sum || uio_out[3] !== prev_carry) held = 1'b0;
            tick();
            n++;
        end
        uio_in = 8'h00;
        check({tag, ".busy_cycles"}, 32'(n), 32'd8);
        check({tag, ".result_held_in_run"}, 32'(held), 32'd1);
        check({tag, ".sum"}, 32'(uo_out), 32'(exp_sum));
        check({tag, ".carry"}, 32'(uio_out[3]), 32'(exp_carry));
        check({tag, ".done"}, 32'(uio_out[5]), 32'd1);
        check({tag, ".uio_oe"}, 32'(uio_oe), 32'h38);
        prev_sum   = exp_sum;
        prev_carry = exp_carry;
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_sum, input logic exp_carry);
        load_ab(a, b);
        run_op(tag, 8'h04, 8'h00, exp_sum, exp_carry, 0);
    endtask

    initial begin
        logic [8:0] model;
        logic [7:0] ra;
        logic [7:0] rb;
        int busy_cnt;
        int rises;
        logic busy_d;

        vecs[0] = '{8'h3C, 8'h5A, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0};

        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        tick();
        tick();
        check("reset.uo_out", 32'(uo_out), 32'h00);
        check("reset.uio_out", 32'(uio_out), 32'h00);
        check("reset.uio_oe", 32'(uio_oe), 32'h38);
        rst_n = 1'b1;
        tick();
        check("idle.uio_out", 32'(uio_out), 32'h00);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry);
        end

        // Random operands against plain arithmetic
        for (int i = 0; i < 20; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            model = {1'b0, ra} + {1'b0, rb};
            do_op($sformatf("rand%0d", i), ra, rb, model[7:0], model[8]);
        end

        // Start held high: exactly one operation
        load_ab(8'h01, 8'h02);
        uio_in   = 8'h04;
        busy_cnt = 0;
        rises    = 0;
        busy_d   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (uio_out[4] === 1'b1) busy_cnt++;
            if (uio_out[4] === 1'b1 && !busy_d) rises++;
            busy_d = uio_out[4];
        end
        check("hold.busy_cycles", 32'(busy_cnt), 32'd8);
        check("hold.busy_windows", 32'(rises), 32'd1);
        check("hold.sum", 32'(uo_out), 32'h03);
        check("hold.done", 32'(uio_out[5]), 32'd1);
        uio_in     = 8'h00;
        tick();
        prev_sum   = 8'h03;
        prev_carry = 1'b0;

        // load_a during RUN cycle 3 is ignored and A shifts out to zero
        load_ab(8'h10, 8'h20);
        run_op("runload", 8'h04, 8'h00, 8'h30, 1'b0, 3);
        ui_in  = 8'h01;
        uio_in = 8'h02;
        tick();
        uio_in = 8'h00;
        run_op("runload_a_zero", 8'h04, 8'h00, 8'h01, 1'b0, 0);

        // Reset during RUN cycle 4
        load_ab(8'h10, 8'h20);
        uio_in = 8'h04;
        tick();
        uio_in = 8'h00;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset.uo_out", 32'(uo_out), 32'h00);
        check("midreset.uio_out", 32'(uio_out), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("midreset.stays_idle", 32'(uio_out), 32'h00);
        prev_sum   = 8'h00;
        prev_carry = 1'b0;
        do_op("after_reset", 8'h07, 8'h09, 8'h10, 1'b0);

        // Load presented with the start edge is ignored
        load_ab(8'h11, 8'h22);
        run_op("start_beats_load", 8'h05, 8'h55, 8'h33, 1'b0, 0);

        // Start already high when reset releases triggers at first edge
        rst_n  = 1'b0;
        uio_in = 8'h04;
        tick();
        prev_sum   = 8'h00;
        prev_carry = 1'b0;
        rst_n = 1'b1;
        run_op("start_at_release", 8'h04, 8'h00, 8'h00, 1'b0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tt_um_serial_adder
`default_nettype wire
